// File: rtl/fp_div_seq.sv
// -----------------------------------------------------------------------------
// fp_div_seq_pkg / fp_div_seq
//
// Multi-cycle IEEE-754 divider producing an unrounded result for a separate
// rounding stage. Operands are classified when a start is accepted. Special
// cases (NaN, zero, infinity) finish on the next cycle. Every other operand
// pair goes through PREP (subnormal normalisation and exponent), ITER
// (restoring radix-2 divide) and NORM (alignment, subnormal shift, sticky).
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous, active-high reset
//   a_i, b_i       dividend / divisor, FP_WIDTH bits
//   rnd_i          rounding mode, captured with the operands, not used here
//   start_i        request, accepted only while ready_o=1
//   ready_o        high in IDLE and FIN
//   done_o         one-cycle pulse in the first FIN cycle of each result
//   urnd_result_o  {u_result, rs, round_en, invalid, exp_cout}
//   dz_o           divide-by-zero, valid with the result
//
// u_result is UResultWidth bits wide so one port type serves every format.
// The active format sits right-aligned as {sign, exp, mant}. The upper bits
// are zero.
// -----------------------------------------------------------------------------
package fp_div_seq_pkg;

    typedef enum logic [1:0] {FP16, FP32, FP64} fp_format_e;

    typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM} roundmode_e;

    localparam int unsigned UResultWidth = 64;

    typedef struct packed {
        logic [UResultWidth-1:0] u_result;
        logic [1:0]              rs;        // {round bit, sticky}
        logic                    round_en;
        logic                    invalid;
        logic [1:0]              exp_cout;  // top bits of the wide exponent
    } uround_res_t;

    function automatic int unsigned fp_exp_width(fp_format_e fmt);
        case (fmt)
            FP16:    return 5;
            FP64:    return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned fp_mant_width(fp_format_e fmt);
        case (fmt)
            FP16:    return 10;
            FP64:    return 52;
            default: return 23;
        endcase
    endfunction

endpackage

module fp_div_seq
    import fp_div_seq_pkg::*;
#(
    parameter fp_format_e   FP_FORMAT      = FP32,
    parameter int unsigned  ITER_PER_CYCLE = 1,    // 1, 2 or 4
    localparam int unsigned EXP_WIDTH      = fp_exp_width(FP_FORMAT),
    localparam int unsigned MANT_WIDTH     = fp_mant_width(FP_FORMAT),
    localparam int unsigned FP_WIDTH       = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [FP_WIDTH-1:0] a_i,
    input  logic [FP_WIDTH-1:0] b_i,
    input  roundmode_e          rnd_i,
    input  logic                start_i,
    output logic                ready_o,
    output logic                done_o,
    output uround_res_t         urnd_result_o,
    output logic                dz_o
);

    localparam int unsigned BIAS     = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int unsigned QBits    = MANT_WIDTH + 3;  // hidden + mant + round + 1
    localparam int unsigned NumIter  = (QBits + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    localparam int unsigned QRegBits = NumIter * ITER_PER_CYCLE;
    localparam int unsigned ExpW     = EXP_WIDTH + 2;
    localparam int unsigned CntW     = $clog2(NumIter + 1);
    localparam int unsigned LzW      = $clog2(MANT_WIDTH + 2);
    localparam int unsigned RemW     = MANT_WIDTH + 2;
    // Quotient bits computed beyond QBits (ITER_PER_CYCLE not dividing QBits)
    // only feed the sticky bit.
    localparam logic [QRegBits-1:0] ExtraMask =
        QRegBits'((64'd1 << (QRegBits - QBits)) - 64'd1);

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StNorm, StFin} state_e;

    state_e                   state_q;
    logic [FP_WIDTH-1:0]      a_q, b_q;
    roundmode_e               rnd_q;
    logic                     sign_q;
    logic signed [ExpW-1:0]   exp_q;
    logic [RemW-1:0]          rem_q;
    logic [MANT_WIDTH:0]      div_q;
    logic [QRegBits-1:0]      quot_q;
    logic [CntW-1:0]          cnt_q;
    uround_res_t              res_q;
    logic                     dz_q;
    logic                     done_q;

    // ---------------------------------------------------------------------
    // Operand classification on the live inputs (used at acceptance)
    // ---------------------------------------------------------------------
    logic [EXP_WIDTH-1:0]  ea_i, eb_i;
    logic [MANT_WIDTH-1:0] fa_i, fb_i;
    logic                  a_zero, a_inf, a_nan, a_snan;
    logic                  b_zero, b_inf, b_nan, b_snan;
    logic                  sign_in, special;
    logic [FP_WIDTH-1:0]   spec_fp;
    logic                  spec_inv, spec_dz;
    uround_res_t           spec_res;

    assign ea_i = a_i[FP_WIDTH-2 -: EXP_WIDTH];
    assign eb_i = b_i[FP_WIDTH-2 -: EXP_WIDTH];
    assign fa_i = a_i[MANT_WIDTH-1:0];
    assign fb_i = b_i[MANT_WIDTH-1:0];

    assign a_zero = (ea_i == '0) && (fa_i == '0);
    assign b_zero = (eb_i == '0) && (fb_i == '0);
    assign a_inf  = (&ea_i) && (fa_i == '0);
    assign b_inf  = (&eb_i) && (fb_i == '0);
    assign a_nan  = (&ea_i) && (fa_i != '0);
    assign b_nan  = (&eb_i) && (fb_i != '0);
    assign a_snan = a_nan && !fa_i[MANT_WIDTH-1];
    assign b_snan = b_nan && !fb_i[MANT_WIDTH-1];

    assign sign_in = a_i[FP_WIDTH-1] ^ b_i[FP_WIDTH-1];
    assign special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

    always_comb begin
        spec_fp  = {sign_in, {(FP_WIDTH-1){1'b0}}};
        spec_inv = 1'b0;
        spec_dz  = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            // Default quiet NaN
            spec_fp  = {1'b1, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
            spec_inv = (a_zero && b_zero) || (a_inf && b_inf) || a_snan || b_snan;
        end else if (b_zero) begin
            spec_fp = {sign_in, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            spec_dz = 1'b1;
        end else if (a_inf) begin
            spec_fp = {sign_in, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        end
        // Remaining cases (finite/inf, 0/finite) keep the signed zero.
    end

    always_comb begin
        spec_res          = '0;
        spec_res.u_result = UResultWidth'(spec_fp);
        spec_res.invalid  = spec_inv;
    end

    // ---------------------------------------------------------------------
    // PREP: normalise subnormal significands and form the biased exponent
    // ---------------------------------------------------------------------
    logic [EXP_WIDTH-1:0]   ea_q, eb_q, ea_adj, eb_adj;
    logic [MANT_WIDTH:0]    ma_raw, mb_raw, ma_norm, mb_norm;
    logic [LzW-1:0]         lz_a, lz_b;
    logic signed [ExpW-1:0] ea_eff, eb_eff, exp_prep;

    assign ea_q = a_q[FP_WIDTH-2 -: EXP_WIDTH];
    assign eb_q = b_q[FP_WIDTH-2 -: EXP_WIDTH];

    always_comb begin
        ma_raw = {|ea_q, a_q[MANT_WIDTH-1:0]};
        mb_raw = {|eb_q, b_q[MANT_WIDTH-1:0]};
        lz_a   = '0;
        lz_b   = '0;
        // The highest set bit is visited last, so its count wins.
        for (int i = 0; i <= MANT_WIDTH; i++) begin
            if (ma_raw[i]) lz_a = LzW'(MANT_WIDTH - i);
            if (mb_raw[i]) lz_b = LzW'(MANT_WIDTH - i);
        end
        ma_norm = ma_raw << lz_a;
        mb_norm = mb_raw << lz_b;

        // A subnormal has effective exponent 1, less its normalisation shift.
        ea_adj   = (ea_q == '0) ? EXP_WIDTH'(1) : ea_q;
        eb_adj   = (eb_q == '0) ? EXP_WIDTH'(1) : eb_q;
        ea_eff   = $signed({2'b00, ea_adj}) - $signed(ExpW'(lz_a));
        eb_eff   = $signed({2'b00, eb_adj}) - $signed(ExpW'(lz_b));
        exp_prep = ea_eff - eb_eff + $signed(ExpW'(BIAS));
    end

    // ---------------------------------------------------------------------
    // ITER: ITER_PER_CYCLE restoring steps per cycle
    // ---------------------------------------------------------------------
    logic [RemW-1:0]     rem_n;
    logic [QRegBits-1:0] quot_n;

    always_comb begin
        rem_n  = rem_q;
        quot_n = quot_q;
        for (int k = 0; k < ITER_PER_CYCLE; k++) begin
            if (rem_n >= {1'b0, div_q}) begin
                rem_n  = rem_n - {1'b0, div_q};
                quot_n = {quot_n[QRegBits-2:0], 1'b1};
            end else begin
                quot_n = {quot_n[QRegBits-2:0], 1'b0};
            end
            rem_n = rem_n << 1;
        end
    end

    // ---------------------------------------------------------------------
    // NORM: one-bit left align, subnormal right shift, round/sticky
    // ---------------------------------------------------------------------
    logic [QBits-1:0]       q_sig, n_sig;
    logic [2*QBits-1:0]     n_wide;
    logic signed [ExpW-1:0] n_exp;
    logic [ExpW-1:0]        n_sh;
    logic                   n_lost, n_rnz;
    uround_res_t            norm_res;

    always_comb begin
        q_sig  = quot_q[QRegBits-1 -: QBits];
        n_rnz  = (|rem_q) | (|(quot_q & ExtraMask));
        n_sig  = q_sig;
        n_exp  = exp_q;
        n_lost = 1'b0;
        n_wide = '0;
        n_sh   = '0;
        if (!q_sig[QBits-1]) begin
            n_sig = q_sig << 1;
            n_exp = exp_q - ExpW'(1);
        end
        if (n_exp[ExpW-1] || (n_exp == '0)) begin
            n_sh = ExpW'(1) - n_exp;
            if (n_sh > ExpW'(QBits)) n_sh = ExpW'(QBits);
            // The low half of the wide vector collects the bits shifted out.
            n_wide = {n_sig, {QBits{1'b0}}} >> n_sh;
            n_sig  = n_wide[2*QBits-1 -: QBits];
            n_lost = |n_wide[QBits-1:0];
            n_exp  = '0;
        end

        norm_res          = '0;
        norm_res.u_result = UResultWidth'({sign_q, n_exp[EXP_WIDTH-1:0], n_sig[QBits-2:2]});
        norm_res.rs       = {n_sig[1], n_sig[0] | n_lost | n_rnz};
        norm_res.round_en = 1'b1;
        norm_res.exp_cout = n_exp[ExpW-1 -: 2];
    end

    // The rounding mode rides along for the downstream rounder. The hidden
    // bit is implied by the exponent field.
    logic unused_bits;
    assign unused_bits = ^{rnd_q, n_sig[QBits-1]};

    // ---------------------------------------------------------------------
    // Control FSM and all state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            rnd_q   <= RNE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StFin: begin
                    if (start_i) begin
                        a_q   <= a_i;
                        b_q   <= b_i;
                        rnd_q <= rnd_i;
                        if (special) begin
                            res_q   <= spec_res;
                            dz_q    <= spec_dz;
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            state_q <= StPrep;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StPrep: begin
                    sign_q  <= a_q[FP_WIDTH-1] ^ b_q[FP_WIDTH-1];
                    exp_q   <= exp_prep;
                    rem_q   <= {1'b0, ma_norm};
                    div_q   <= mb_norm;
                    quot_q  <= '0;
                    cnt_q   <= CntW'(NumIter);
                    state_q <= StIter;
                end
                StIter: begin
                    rem_q  <= rem_n;
                    quot_q <= quot_n;
                    cnt_q  <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) state_q <= StNorm;
                end
                StNorm: begin
                    res_q   <= norm_res;
                    dz_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StFin;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o       = (state_q == StIdle) || (state_q == StFin);
    assign done_o        = done_q;
    assign urnd_result_o = res_q;
    assign dz_o          = dz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq (FP32, one quotient bit per cycle).
module tb_fp_div_seq;
    import fp_div_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] a_i, b_i;
    roundmode_e  rnd_i;
    logic        start_i;
    logic        ready_o, done_o, dz_o;
    uround_res_t res;

    int n_total = 0;
    int n_bad   = 0;
    int lat;
    logic saw_done;

    fp_div_seq #(
        .FP_FORMAT     (FP32),
        .ITER_PER_CYCLE(1)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .rnd_i        (rnd_i),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .done_o       (done_o),
        .urnd_result_o(res),
        .dz_o         (dz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Start one operation from the current cycle and wait for done_o.
    // lat counts the acceptance cycle as cycle 0.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] u, input logic [1:0] rs, input logic ren,
                           input logic inv, input logic [1:0] cout, input logic dz,
                           input int lat_want);
        int l;
        a_i     = a;
        b_i     = b;
        rnd_i   = RUP;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        a_i     = 32'h12345678;  // later operand changes must not matter
        b_i     = 32'h3F800000;
        l       = 1;
        while (!done_o && l < 100) begin
            @(posedge clk_i);
            #1;
            l++;
        end
        check_eq({tag, ".lat"}, 64'(l), 64'(lat_want));
        check_eq({tag, ".u"}, res.u_result, u);
        check_eq({tag, ".rs"}, 64'(res.rs), 64'(rs));
        check_eq({tag, ".ren"}, 64'(res.round_en), 64'(ren));
        check_eq({tag, ".inv"}, 64'(res.invalid), 64'(inv));
        check_eq({tag, ".cout"}, 64'(res.exp_cout), 64'(cout));
        check_eq({tag, ".dz"}, 64'(dz_o), 64'(dz));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".ready"}, 64'(ready_o), 64'd1);
        check_eq({tag, ".done"}, 64'(done_o), 64'd0);
        check_eq({tag, ".dz"}, 64'(dz_o), 64'd0);
        check_eq({tag, ".res"}, 64'(res), 64'd0);
    endtask

    initial begin
        // Reset, with a start held high that must be ignored.
        reset_i = 1'b1;
        start_i = 1'b1;
        a_i     = 32'h3F800000;
        b_i     = 32'h00000000;
        rnd_i   = RNE;
        repeat (2) @(posedge clk_i);
        #1;
        check_idle("rst");
        reset_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_eq("rst.nodone", 64'(done_o), 64'd0);

        // Normal path; the second and later runs start back-to-back from FIN.
        run_vec("six_two", 32'h40C00000, 32'h40000000, 64'h40400000, 2'b00, 1, 0, 2'b00, 0, 29);
        run_vec("one_three", 32'h3F800000, 32'h40400000, 64'h3EAAAAAA, 2'b11, 1, 0, 2'b00, 0, 29);
        run_vec("one_zero", 32'h3F800000, 32'h00000000, 64'h7F800000, 2'b00, 0, 0, 2'b00, 1, 1);
        run_vec("zero_zero", 32'h00000000, 32'h00000000, 64'hFFC00000, 2'b00, 0, 1, 2'b00, 0, 1);

        // done_o is a single pulse; the result holds.
        @(posedge clk_i);
        #1;
        check_eq("hold.done", 64'(done_o), 64'd0);
        check_eq("hold.u", res.u_result, 64'hFFC00000);
        check_eq("hold.inv", 64'(res.invalid), 64'd1);
        check_eq("hold.ready", 64'(ready_o), 64'd1);

        run_vec("min_norm", 32'h00800000, 32'h40000000, 64'h00400000, 2'b00, 1, 0, 2'b00, 0, 29);
        run_vec("neg", 32'hC0C00000, 32'h40000000, 64'hC0400000, 2'b00, 1, 0, 2'b00, 0, 29);
        run_vec("ten_five", 32'h41200000, 32'h40A00000, 64'h40000000, 2'b00, 1, 0, 2'b00, 0, 29);
        run_vec("ovf", 32'h7F000000, 32'h3E800000, 64'h00000000, 2'b00, 1, 0, 2'b01, 0, 29);
        run_vec("sub_min", 32'h00000001, 32'h3F800000, 64'h00000001, 2'b00, 1, 0, 2'b00, 0, 29);
        run_vec("inf_fin", 32'h7F800000, 32'h40000000, 64'h7F800000, 2'b00, 0, 0, 2'b00, 0, 1);
        run_vec("fin_ninf", 32'h40000000, 32'hFF800000, 64'h80000000, 2'b00, 0, 0, 2'b00, 0, 1);
        run_vec("zero_neg", 32'h00000000, 32'hC0400000, 64'h80000000, 2'b00, 0, 0, 2'b00, 0, 1);
        run_vec("snan", 32'h7F800001, 32'h3F800000, 64'hFFC00000, 2'b00, 0, 1, 2'b00, 0, 1);
        run_vec("qnan", 32'h7FC00000, 32'h3F800000, 64'hFFC00000, 2'b00, 0, 0, 2'b00, 0, 1);
        run_vec("inf_inf", 32'h7F800000, 32'hFF800000, 64'hFFC00000, 2'b00, 0, 1, 2'b00, 0, 1);

        // Start while busy (iteration 5) is ignored.
        a_i     = 32'h40C00000;
        b_i     = 32'h40000000;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        lat     = 1;
        while (!done_o && lat < 100) begin
            if (lat == 6) begin
                a_i     = 32'h3F800000;
                b_i     = 32'h00000000;
                start_i = 1'b1;
                check_eq("busy.ready", 64'(ready_o), 64'd0);
            end
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            lat++;
        end
        check_eq("busy.lat", 64'(lat), 64'd29);
        check_eq("busy.u", res.u_result, 64'h40400000);
        check_eq("busy.dz", 64'(dz_o), 64'd0);

        // Reset at iteration 10, with a start that must also be ignored.
        a_i     = 32'h40C00000;
        b_i     = 32'h40000000;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) begin
            @(posedge clk_i);
            #1;
        end
        check_eq("mid.ready", 64'(ready_o), 64'd0);
        reset_i = 1'b1;
        start_i = 1'b1;
        a_i     = 32'h3F800000;
        b_i     = 32'h00000000;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        start_i = 1'b0;
        check_idle("midrst");
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            saw_done = saw_done | done_o;
        end
        check_eq("midrst.nodone", 64'(saw_done), 64'd0);
        check_eq("midrst.ready2", 64'(ready_o), 64'd1);
        run_vec("after_rst", 32'h40C00000, 32'h40000000, 64'h40400000, 2'b00, 1, 0, 2'b00, 0, 29);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
